// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control FSM: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, emits datapath strobes, handshakes with
// instruction/data memory (bounded wait), counts retired instructions.
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds o_stall_cycles, a count
// of enabled cycles spent waiting on a memory ready.
module multicycle_control_fsm #(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic                i_en,
    input  logic [6:0]          i_opcode,
    input  logic                i_imem_ready,
    input  logic                i_dmem_ready,
    output logic                o_imem_req,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic                o_ir_write,
    output logic                o_pc_write,
    output logic                o_branch,
    output logic                o_jump,
    output logic                o_alu_src,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_mem_2_reg,
    output logic                o_reg_write,
    output logic                o_busy,
    output logic                o_error,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [CNT_W-1:0]    o_stall_cycles,
`endif
    output logic [CNT_W-1:0]    o_retired
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_R_TYPE = ALU_OP_W'(2);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;

    // Last wait count before a memory timeout; the TIMEOUT-th unready cycle faults.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StError
    } state_e;

    typedef enum logic [2:0] {
        OpR,
        OpI,
        OpBeq,
        OpJal,
        OpLw,
        OpSw
    } op_e;

    state_e              r_state;
    op_e                 r_op;
    logic [7:0]          r_wait;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic                r_alu_src;
    logic                r_mem_2_reg;
    logic [CNT_W-1:0]    r_retired;

    op_e                 w_dec_op;
    logic                w_legal;
    logic [ALU_OP_W-1:0] w_dec_alu_op;
    logic                w_dec_alu_src;
    logic                w_in_fetch;
    logic                w_in_mem;

    // Classify the incoming opcode and pick the ALU controls used in EXEC.
    always_comb begin
        w_legal       = 1'b1;
        w_dec_op      = OpR;
        w_dec_alu_op  = ALU_ADD;
        w_dec_alu_src = 1'b1;
        case (i_opcode)
            OPC_R: begin
                w_dec_op      = OpR;
                w_dec_alu_op  = ALU_R_TYPE;
                w_dec_alu_src = 1'b0;
            end
            OPC_I:   w_dec_op = OpI;
            OPC_LW:  w_dec_op = OpLw;
            OPC_SW:  w_dec_op = OpSw;
            OPC_BEQ: begin
                w_dec_op      = OpBeq;
                w_dec_alu_op  = ALU_SUB;
                w_dec_alu_src = 1'b0;
            end
            OPC_JAL: w_dec_op = OpJal;
            default: w_legal = 1'b0;
        endcase
    end

    // Sequencer: state, opcode latch, wait counter, level outputs, retire count.
    // Nothing advances while i_en is low, so a ready seen then is ignored.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state     <= StFetch;
            r_op        <= OpR;
            r_wait      <= '0;
            r_alu_op    <= ALU_ADD;
            r_alu_src   <= 1'b0;
            r_mem_2_reg <= 1'b0;
            r_retired   <= '0;
        end else if (i_en) begin
            unique case (r_state)
                StFetch: begin
                    if (i_imem_ready) begin
                        r_wait  <= '0;
                        r_state <= StDecode;
                    end else if (r_wait == WAIT_LAST) begin
                        r_wait      <= '0;
                        r_alu_op    <= ALU_ADD;
                        r_alu_src   <= 1'b0;
                        r_mem_2_reg <= 1'b0;
                        r_state     <= StError;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                StDecode: begin
                    if (w_legal) begin
                        r_op      <= w_dec_op;
                        r_alu_op  <= w_dec_alu_op;
                        r_alu_src <= w_dec_alu_src;
                        r_state   <= StExec;
                    end else begin
                        r_alu_op    <= ALU_ADD;
                        r_alu_src   <= 1'b0;
                        r_mem_2_reg <= 1'b0;
                        r_state     <= StError;
                    end
                end
                StExec: begin
                    unique case (r_op)
                        OpR, OpI: r_state <= StWb;
                        OpLw, OpSw: begin
                            r_wait  <= '0;
                            r_state <= StMem;
                        end
                        OpBeq, OpJal: begin
                            r_retired <= r_retired + CNT_W'(1);
                            r_state   <= StFetch;
                        end
                        default: r_state <= StError;
                    endcase
                end
                StMem: begin
                    if (i_dmem_ready) begin
                        r_wait <= '0;
                        if (r_op == OpLw) begin
                            r_mem_2_reg <= 1'b1;
                            r_state     <= StWb;
                        end else begin
                            r_retired <= r_retired + CNT_W'(1);
                            r_state   <= StFetch;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_wait      <= '0;
                        r_alu_op    <= ALU_ADD;
                        r_alu_src   <= 1'b0;
                        r_mem_2_reg <= 1'b0;
                        r_state     <= StError;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                StWb: begin
                    r_retired   <= r_retired + CNT_W'(1);
                    r_mem_2_reg <= 1'b0;
                    r_state     <= StFetch;
                end
                StError: r_state <= StError;
                default: r_state <= StError;
            endcase
        end
    end

    assign w_in_fetch = (r_state == StFetch);
    assign w_in_mem   = (r_state == StMem);

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;

    // Count enabled cycles where a memory request is outstanding but not ready.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_stall_cycles <= '0;
        end else if (i_en && ((w_in_fetch && !i_imem_ready) || (w_in_mem && !i_dmem_ready))) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

    // Single-cycle strobes are qualified by i_en so a frozen block drives nothing.
    assign o_imem_req  = i_en && w_in_fetch;
    assign o_ir_write  = i_en && w_in_fetch && i_imem_ready;
    assign o_pc_write  = i_en && w_in_fetch && i_imem_ready;
    assign o_branch    = i_en && (r_state == StExec) && (r_op == OpBeq);
    assign o_jump      = i_en && (r_state == StExec) && (r_op == OpJal);
    assign o_dmem_req  = i_en && w_in_mem;
    assign o_dmem_we   = i_en && w_in_mem && (r_op == OpSw);
    assign o_reg_write = i_en && (r_state == StWb);

    assign o_alu_op    = r_alu_op;
    assign o_alu_src   = r_alu_src;
    assign o_mem_2_reg = r_mem_2_reg;
    assign o_busy      = !(w_in_fetch || (r_state == StError));
    assign o_error     = (r_state == StError);
    assign o_retired   = r_retired;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequenced successor to the single-cycle opcode decoder, for the multi-cycle RISC-V datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and emits per-state datapath strobes.
- Handshakes with instruction and data memory using req/ready, with a bounded wait timeout.
- Counts retired instructions and flags illegal opcodes or memory timeouts.

Parameters:
- ALU_OP_W, 2, width of alu_op; values are ADD=0, SUB=1, R_TYPE=2.
- TIMEOUT, 15, maximum wait cycles for a memory ready before ERROR; range 1..255.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance enable; 0 freezes the block.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- imem_ready  in  1  instruction memory ready.
- dmem_ready  in  1  data memory ready.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (store).
- ir_write  out  1  IR load strobe.
- pc_write  out  1  PC <= PC+4 strobe.
- branch  out  1  conditional PC update (on zero flag) strobe.
- jump  out  1  unconditional PC <= PC+imm strobe.
- alu_src  out  1  ALU B operand: 1 selects immediate.
- alu_op  out  ALU_OP_W  ALU control class.
- mem_2_reg  out  1  write-back selects memory data.
- reg_write  out  1  register file write strobe.
- busy  out  1  1 in every state except FETCH-idle and ERROR.
- error  out  1  sticky fault flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, arst_n=0):
  - state=FETCH; all strobes, error, retired and the wait counter = 0.
  - Reset mid-operation abandons the instruction with no retire.
- en=0: state, wait counter and retired hold; all single-cycle strobes (ir_write, pc_write, branch, jump, reg_write, dmem_req, imem_req) forced 0. Level outputs alu_op, alu_src and mem_2_reg hold.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_write=1 and pc_write=1 that cycle, wait counter cleared, go to DECODE.
  - Otherwise the wait counter increments; on reaching TIMEOUT go to ERROR.
- DECODE:
  - Register opcode into an internal latch used by later states.
  - Legal opcodes: 0110011 R, 0010011 I, 1100011 BEQ, 1101111 JAL, 0000011 LW, 0100011 SW.
  - Illegal opcode: go to ERROR. Otherwise go to EXEC.
- EXEC outputs and next state:
  - R: alu_src=0, alu_op=R_TYPE; next WB.
  - I: alu_src=1, alu_op=ADD; next WB.
  - LW/SW: alu_src=1, alu_op=ADD; next MEM.
  - BEQ: alu_op=SUB, branch=1 for one cycle; retire; next FETCH.
  - JAL: jump=1 for one cycle; retire; next FETCH.
- MEM:
  - dmem_req=1 held until dmem_ready; dmem_we=1 for SW.
  - On ready, LW goes to WB; SW retires and goes to FETCH.
  - Same timeout rule as FETCH.
- WB: reg_write=1 for one cycle; mem_2_reg=1 only for LW; retire; next FETCH.
- ERROR:
  - error=1, all strobes 0, busy=0.
  - Exits only on reset.
- Retire: retired increments by 1 on the retiring cycle and wraps modulo 2^CNT_W.
- Latency with zero-wait memory (ready same cycle as req):
  - BEQ/JAL: 3 cycles.
  - R/I/SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Ready arriving while en=0 is ignored; the request is held until en=1.
- The ready input is sampled only in the matching state.

Optional Feature:
- MULTICYCLE_CTRL_PERF_EN defined:
  - Adds output stall_cycles (CNT_W): counts cycles spent in FETCH or MEM with req=1 and ready=0 while en=1.
  - Reset 0; wraps modulo 2^CNT_W.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory, R-type then LW: imem/dmem_ready tied 1 -> R-type retires after 4 cycles, LW after a further 5. reg_write pulses twice; mem_2_reg=1 only in the LW WB cycle; retired=2.
- SW with dmem_ready delayed 3 cycles -> dmem_req and dmem_we held 4 cycles; no reg_write; retire at cycle 7; stall_cycles=3 when PERF_EN is defined.
- BEQ then JAL -> branch pulses 1 cycle with alu_op=1 in the 3rd cycle; jump pulses in the 6th cycle; retired=2.
- opcode=1111111 -> ERROR after DECODE; error=1, busy=0; all strobes stay 0 for 20 cycles; arst_n pulse clears error and returns to FETCH.
- imem_ready held 0 with TIMEOUT=15 -> ERROR entered after 15 wait cycles. Separately, ready asserted on the 15th cycle -> normal DECODE.
- en=0 for 5 cycles during MEM, with dmem_ready=1 in that window -> no dmem_req and no state change; after en=1 the access completes normally. Reset asserted mid-WB -> reg_write=0 immediately, retired unchanged.
